bitstream_serializer: RTL
=========================

Name: bitstream_serializer

Overview:
Parallel-to-serial feeder for the programmable sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It shifts each word out MSB-first, one bit per clk, on dout; dout connects directly to the detector's din. Words with data waiting stream with no gaps; idle cycles drive IDLE_BIT.

Parameters:
WIDTH, 8, data word width in bits (2..32)
DEPTH, 4, FIFO depth in words (power of 2, >=2)
IDLE_BIT, 1'b0, value driven on dout when no valid bit is being emitted

Ports:
clk  input  1  clock, all logic on rising edge
resetn  input  1  reset, synchronous, active-low
in_data  input  WIDTH  word to serialize
in_valid  input  1  in_data valid
in_ready  output  1  FIFO can accept a word this cycle
dout  output  1  serial bit, registered
dout_valid  output  1  dout carries a data (or parity) bit, registered
busy  output  1  shifter active or FIFO non-empty
underrun  output  1  one-cycle pulse when the stream runs dry
fifo_level  output  $clog2(DEPTH)+1  words currently held in the FIFO

Behaviour:
- Reset (resetn low at a clk edge):
  - FIFO pointers and level cleared to 0; shifter state IDLE; bit counter 0.
  - dout=IDLE_BIT, dout_valid=0, underrun=0, busy=0.
  - in_ready forced 0 while resetn is low.
- Reset mid-operation: in-flight word and all FIFO contents are discarded. No underrun pulse is generated by the reset.
- Push: occurs when in_valid && in_ready.
  - in_ready = resetn && (fifo_level < DEPTH), combinational from registered level.
  - A pop in the same cycle does not raise in_ready when the FIFO is full; no push occurs while full.
- FSM states:
  - IDLE -> LOAD when FIFO is non-empty.
  - SHIFT: emits one bit per cycle; bit counter counts 0..FRAME-1, where FRAME=WIDTH (FRAME=WIDTH+1 with parity).
  - On the last bit: if the FIFO is non-empty, pop and reload (stay SHIFT, no gap); else go to IDLE.
  - Reload is implemented as pop-on-last-bit. LOAD is a conceptual single pop step, not an extra cycle.
- Latency:
  - A word pushed at edge N into an empty FIFO with the shifter IDLE is popped at edge N+1.
  - dout=in_data[WIDTH-1] with dout_valid=1 after edge N+1.
  - The following WIDTH-1 edges present bits WIDTH-2..0.
- dout is 0-latency from the shift register MSB. dout_valid is high for exactly FRAME cycles per word.
- Back-to-back words: after bit 0 of word k, the next edge presents the MSB of word k+1. dout_valid stays high with no bubble.
- fifo_level updates:
  - +1 on push only, -1 on pop only, unchanged on push and pop together.
  - Never exceeds DEPTH and never goes below 0.
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- underrun: 1 for exactly one cycle, in the first cycle dout_valid is 0 after having been 1.
- busy = (state==SHIFT) || (fifo_level!=0).

Optional Feature:
SER_PARITY_EN.
- Defined: after bit 0 of each word, one extra bit equal to the XOR of all WIDTH data bits (even parity) is emitted with dout_valid=1. FRAME=WIDTH+1, and the next word follows the parity bit with no gap.
- Undefined: no parity bit; FRAME=WIDTH. Parity logic is absent from the netlist.

Test Plan:
1. Single word (WIDTH=8): reset 2 cycles, push 0xA5 at edge N.
   - Cycles N+1..N+8: dout = 1,0,1,0,0,1,0,1 with dout_valid=1.
   - Edge N+9: dout_valid=0, dout=IDLE_BIT, underrun=1 for one cycle.
2. Back-to-back: push 0xF0 then 0x0F on consecutive cycles.
   - 16 contiguous valid bits 11110000 00001111, no bubble.
   - Single underrun pulse after bit 16.
3. Fill/backpressure: in_valid held high with 7 distinct words.
   - fifo_level peaks at 4 and in_ready drops while full.
   - All 7 words emerge in order, MSB-first, with no loss or duplication.
   - Pointer wrap is exercised.
4. Reset mid-word: resetn low after 3 bits of 0xC3, with 2 words queued.
   - Next cycle: dout_valid=0, fifo_level=0, in_ready=0 during reset, no underrun.
   - A fresh 0x81 pushed after reset serializes correctly.
5. Detector chain: stream 0x2D (00101101) into a detector programmed with 5'b01101.
   - The detector flags a match on the cycle after the 8th bit.
6. SER_PARITY_EN defined: push 0x07.
   - 9 valid bits: 00000111 then 1.
   - Next word 0x03 follows immediately and ends with parity bit 0.

Source files
------------

// File: rtl/bitstream_serializer.sv
// rtl/bitstream_serializer.sv - FIFO-buffered MSB-first word serializer (optional SER_PARITY_EN)
// Define SER_PARITY_EN to append an even-parity bit after bit 0 of every word.
module bitstream_serializer #(
  parameter int   WIDTH    = 8,
  parameter int   DEPTH    = 4,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       dout,
  output logic                       dout_valid,
  output logic                       busy,
  output logic                       underrun,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(WIDTH + 2);
`ifdef SER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             underrun_q, underrun_d;
`ifdef SER_PARITY_EN
  logic             par_q, par_d;
`endif

  logic             push, pop, last_bit;
  logic [WIDTH-1:0] head;

  assign in_ready   = resetn && (level_q < LW'(DEPTH));
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign underrun   = underrun_q;
  assign fifo_level = level_q;
  assign busy       = (state_q == S_SHIFT) || (level_q != '0);

  always_comb begin
    push     = in_valid && in_ready;
    last_bit = (state_q == S_SHIFT) && (cnt_q == CW'(FRAME - 1));
    // Reload happens on the last bit so consecutive words leave no gap.
    pop      = (level_q != '0) && ((state_q == S_IDLE) || last_bit);
    head     = mem_q[rd_ptr_q];

    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    state_d      = state_q;
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    underrun_d   = 1'b0;
`ifdef SER_PARITY_EN
    par_d        = par_q;
`endif

    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (pop) begin
      state_d      = S_SHIFT;
      cnt_d        = '0;
      dout_d       = head[WIDTH-1];
      sr_d         = {head[WIDTH-2:0], 1'b0};
      dout_valid_d = 1'b1;
`ifdef SER_PARITY_EN
      par_d        = ^head;
`endif
    end else if (last_bit) begin
      state_d      = S_IDLE;
      cnt_d        = '0;
      dout_d       = IDLE_BIT;
      dout_valid_d = 1'b0;
      underrun_d   = 1'b1;
    end else if (state_q == S_SHIFT) begin
      cnt_d  = cnt_q + CW'(1);
      dout_d = sr_q[WIDTH-1];
      sr_d   = {sr_q[WIDTH-2:0], 1'b0};
`ifdef SER_PARITY_EN
      if (cnt_q == CW'(WIDTH - 1)) begin
        dout_d = par_q;
      end
`endif
    end
  end

  // Storage is not reset; the pointers and level alone define its contents.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      state_q      <= S_IDLE;
      sr_q         <= '0;
      cnt_q        <= '0;
      dout_q       <= IDLE_BIT;
      dout_valid_q <= 1'b0;
      underrun_q   <= 1'b0;
`ifdef SER_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      state_q      <= state_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      underrun_q   <= underrun_d;
`ifdef SER_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

endmodule
